// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller: light encodings,
// timing constants (in 50 MHz clock cycles) and the sensor debounce states.
package tlc_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b11;

    localparam int unsigned ONE_SEC     = 32'd50000000;
    localparam int unsigned THREE_SEC   = 32'd150000000;
    localparam int unsigned FIFTEEN_SEC = 32'd750000000;
    localparam int unsigned THIRTY_SEC  = 32'd1500000000;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } db_state_t;

endpackage

// File: rtl/tlc_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Asynchronous active-high reset clears both stages.
module tlc_sync2 (
    input  logic Clk,
    input  logic Rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to resolve metastability.
    // NOTE: clocked state uses <= so both stages sample their pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tlc_sensor_timer.sv
// Front end for the traffic-light FSM: synchronises and debounces the
// farm-road detector, and provides the saturating interval counter.
// Build option: define TLC_REQ_LATCH_EN to hold a farm demand until the
// farm light turns green.
module tlc_sensor_timer
    import tlc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 31
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             rawSensor,
    input  logic             RstCount,
    input  logic [1:0]       farmSignal,
    output logic [CNT_W-1:0] Count,
    output logic             farmSensor,
    output logic [1:0]       dbState
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            snsSync;
    db_state_t       dbCur, dbNext;
    logic [DB_W-1:0] dbCnt, dbCntNext;
    logic            dbLevel, dbLevelNext;

    tlc_sync2 u_sync (
        .Clk (Clk),
        .Rst (Rst),
        .d   (rawSensor),
        .q   (snsSync)
    );

    // Debounce state, stability counter and accepted level.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dbCur   <= IDLE_LO;
            dbCnt   <= '0;
            dbLevel <= 1'b0;
        end else begin
            dbCur   <= dbNext;
            dbCnt   <= dbCntNext;
            dbLevel <= dbLevelNext;
        end
    end

    // Debounce next-state: a new level is accepted only after DEBOUNCE_CYCLES
    // consecutive matching samples; any contrary sample abandons the attempt.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        dbNext      = dbCur;
        dbCntNext   = dbCnt;
        dbLevelNext = dbLevel;
        unique case (dbCur)
            IDLE_LO: begin
                if (snsSync) begin
                    dbNext    = WAIT_HI;
                    dbCntNext = DB_W'(1);
                end
            end
            WAIT_HI: begin
                if (!snsSync) begin
                    dbNext    = IDLE_LO;
                    dbCntNext = '0;
                end else if (dbCnt == DB_LAST) begin
                    dbNext      = IDLE_HI;
                    dbLevelNext = 1'b1;
                    dbCntNext   = '0;
                end else begin
                    dbCntNext = dbCnt + 1'b1;
                end
            end
            IDLE_HI: begin
                if (!snsSync) begin
                    dbNext    = WAIT_LO;
                    dbCntNext = DB_W'(1);
                end
            end
            WAIT_LO: begin
                if (snsSync) begin
                    dbNext    = IDLE_HI;
                    dbCntNext = '0;
                end else if (dbCnt == DB_LAST) begin
                    dbNext      = IDLE_LO;
                    dbLevelNext = 1'b0;
                    dbCntNext   = '0;
                end else begin
                    dbCntNext = dbCnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dbState = dbCur;

    // Interval counter: cleared on FSM request, otherwise counts up and
    // sticks at all-ones rather than wrapping back to a short interval.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Count <= '0;
        end else if (RstCount) begin
            Count <= '0;
        end else if (!(&Count)) begin
            Count <= Count + 1'b1;
        end
    end

`ifdef TLC_REQ_LATCH_EN
    logic reqLatch;
    logic farmGreen;

    assign farmGreen = (farmSignal == GREEN);

    // Request latch sets on the debounced rising edge and is dropped while
    // the farm light is green (clear has priority); the clear term is applied
    // directly to the output so the demand vanishes one cycle after green.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            reqLatch   <= 1'b0;
            farmSensor <= 1'b0;
        end else begin
            if (farmGreen) begin
                reqLatch <= 1'b0;
            end else if (dbLevelNext && !dbLevel) begin
                reqLatch <= 1'b1;
            end
            farmSensor <= (reqLatch && !farmGreen) || dbLevel;
        end
    end
`else
    // The light state only matters to the request latch; absorb it here.
    logic unused_farm;
    assign unused_farm = &{1'b0, farmSignal};

    // Registered copy of the debounced level.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            farmSensor <= 1'b0;
        end else begin
            farmSensor <= dbLevel;
        end
    end
`endif

endmodule

// File: doc/tlc_sensor_timer.md
Name: tlc_sensor_timer

Overview:
- Front-end stage that feeds the traffic-light controller FSM.
- Synchronises and debounces the raw farm-road vehicle detector and presents a clean `farmSensor`.
- Owns the 31-bit interval counter (`Count`) that the FSM compares against its timing constants; the counter clears on the FSM's `RstCount` request.
- Optional request latch keeps a farm demand pending until the farm light has gone green.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable samples needed to accept a sensor edge (1 ms at 50 MHz); legal range 2..2^20.
- CNT_W, 31, width of `Count`; must hold the 30-second constant 1500000000.

Ports:
- Clk  input  1  system clock, 50 MHz.
- Rst  input  1  reset; asynchronous, active-high.
- rawSensor  input  1  asynchronous vehicle detector, may bounce.
- RstCount  input  1  from the FSM; clear `Count`.
- farmSignal  input  2  from the FSM; current farm light (red=00, yellow=01, green=11).
- Count  output  CNT_W  interval count to the FSM.
- farmSensor  output  1  conditioned farm demand to the FSM.
- dbState  output  2  debounce state, for debug.

Behaviour:
- Reset (async, immediate, including mid-debounce or mid-count):
  - Both synchroniser flops are 0.
  - dbState = IDLE_LO, debounce counter = 0, debounced level = 0, request latch = 0.
  - Count = 0, farmSensor = 0.
- Synchroniser:
  - rawSensor passes through two flops, giving `snsSync`.
  - Latency from rawSensor to snsSync is 2 cycles.
- Debounce FSM, states IDLE_LO=00, WAIT_HI=01, IDLE_HI=10, WAIT_LO=11:
  - IDLE_LO: if snsSync=1, go to WAIT_HI with dbCnt=1.
  - WAIT_HI: if snsSync=0, return to IDLE_LO and clear dbCnt.
  - WAIT_HI: else if dbCnt = DEBOUNCE_CYCLES-1, go to IDLE_HI, set dbLevel=1, clear dbCnt.
  - WAIT_HI: otherwise dbCnt increments.
  - IDLE_HI and WAIT_LO mirror the above with polarity inverted; dbLevel goes to 0 on entry to IDLE_LO from WAIT_LO.
  - A pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes dbLevel.
  - Total latency from a clean rawSensor edge to a dbLevel change is DEBOUNCE_CYCLES+2 cycles.
  - dbCnt width is $clog2(DEBOUNCE_CYCLES).
- Interval counter:
  - If RstCount=1 at a rising Clk edge, Count <= 0.
  - Otherwise, if Count is all-ones, it holds (saturates, never wraps).
  - Otherwise Count <= Count+1.
  - RstCount is combinational from the FSM and is sampled only at the clock edge.
  - Count is 0 in the cycle after RstCount is sampled high.
  - Count increments every cycle regardless of sensor activity.
- Output:
  - farmSensor is registered.
  - Without the optional feature it equals dbLevel, delayed one cycle.

Optional Feature:
- Macro: TLC_REQ_LATCH_EN.
- Defined:
  - A request latch sets on the dbLevel 0->1 transition.
  - It clears in any cycle where farmSignal==11 (green).
  - If set and clear occur in the same cycle, clear wins.
  - farmSensor <= reqLatch | dbLevel, so a vehicle that drives off before the farm light turns green still gets served.
- Undefined:
  - No latch is built; farmSensor <= dbLevel.
  - The farmSignal input is left unused.

Decomposition:
- Package tlc_pkg holds:
  - Light encodings RED=2'b00, YELLOW=2'b01, GREEN=2'b11.
  - Timing constants ONE_SEC=50000000, THREE_SEC=150000000, FIFTEEN_SEC=750000000, THIRTY_SEC=1500000000.
  - The debounce state encoding.
- The FSM and this block both import tlc_pkg.
- One sub-module: tlc_sync2, a 2-flop synchroniser with async active-high reset, reusable for other raw inputs.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset and release, RstCount=0 for 10 cycles -> Count=10, farmSensor=0, dbState=00. Assert Rst asynchronously mid-cycle -> Count=0 with no clock edge.
- rawSensor held high from cycle 0 -> dbState enters 01, then 10. farmSensor=1 at cycle 7 (2 sync + 4 debounce + 1 output), stays 1.
- rawSensor pulses high for 3 cycles, then low -> dbState 01 then back to 00, farmSensor stays 0. Bounce pattern 1,0,1,1,1,1 -> farmSensor rises 7 cycles after the final stable rise.
- RstCount pulsed at Count=150 -> Count=0 next cycle, 1 the cycle after. Force Count to 2^31-2, run 3 cycles -> Count holds 2^31-1.
- With TLC_REQ_LATCH_EN: debounced press then release while farmSignal=00 -> farmSensor stays 1. Drive farmSignal=11 -> farmSensor=0 next cycle. New rising dbLevel in that same cycle is still cleared.
- Without TLC_REQ_LATCH_EN: same stimulus -> farmSensor follows dbLevel; farmSignal has no effect.
